// File: rtl/extram_arbiter_if.sv
// extram_arbiter_if -- bus bundle between the external-RAM arbiter and its
// three neighbours: the VGA scan-out reader, the CPU bus and the SRAM pins.
//
// Signals
//   VGA : I_vga_req, I_vga_adr[18:0], O_vga_dat[7:0]
//   CPU : I_cpu_stb, I_cpu_we, I_cpu_adr[18:0], I_cpu_dat[7:0],
//         O_cpu_ack, O_cpu_dat[7:0]
//   SRAM: O_sram_adr[18:0], O_sram_dat[7:0], O_sram_dat_oe, I_sram_dat[7:0],
//         O_sram_ce_n, O_sram_oe_n, O_sram_we_n
//
// Modports
//   slave  : the arbiter (I_* are inputs, O_* are outputs)
//   master : the surroundings (drive I_*, observe O_*)
interface extram_arbiter_if;
  logic        I_vga_req;
  logic [18:0] I_vga_adr;
  logic [7:0]  O_vga_dat;

  logic        I_cpu_stb;
  logic        I_cpu_we;
  logic [18:0] I_cpu_adr;
  logic [7:0]  I_cpu_dat;
  logic        O_cpu_ack;
  logic [7:0]  O_cpu_dat;

  logic [18:0] O_sram_adr;
  logic [7:0]  O_sram_dat;
  logic        O_sram_dat_oe;
  logic [7:0]  I_sram_dat;
  logic        O_sram_ce_n;
  logic        O_sram_oe_n;
  logic        O_sram_we_n;

  modport slave (
    input  I_vga_req, I_vga_adr,
    output O_vga_dat,
    input  I_cpu_stb, I_cpu_we, I_cpu_adr, I_cpu_dat,
    output O_cpu_ack, O_cpu_dat,
    output O_sram_adr, O_sram_dat, O_sram_dat_oe,
    input  I_sram_dat,
    output O_sram_ce_n, O_sram_oe_n, O_sram_we_n
  );

  modport master (
    output I_vga_req, I_vga_adr,
    input  O_vga_dat,
    output I_cpu_stb, I_cpu_we, I_cpu_adr, I_cpu_dat,
    input  O_cpu_ack, O_cpu_dat,
    input  O_sram_adr, O_sram_dat, O_sram_dat_oe,
    output I_sram_dat,
    input  O_sram_ce_n, O_sram_oe_n, O_sram_we_n
  );
endinterface

// File: rtl/extram_arbiter.sv
// extram_arbiter -- shares one 512K x 8 asynchronous SRAM between the VGA
// scan-out reader and the CPU. Every clock cycle is one SRAM slot (IDLE, VGA,
// CPU_RD or CPU_WR); VGA always wins, the CPU gets the next free slot.
//
// Ports
//   I_vga_clk : single clock, rising edge
//   I_reset   : synchronous, active-high reset
//   bus       : extram_arbiter_if.slave -- VGA read port, CPU strobe/ack
//               port and SRAM pins (data-bus tristate lives outside)
module extram_arbiter (
  input  logic             I_vga_clk,
  input  logic             I_reset,
  extram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_VGA,
    SLOT_CPU_RD,
    SLOT_CPU_WR
  } slot_t;

  slot_t       slot_q, slot_d;

  // cpu_busy_q marks that the current strobe assertion was already accepted,
  // so a strobe held high past its ack never starts a second access.
  logic        cpu_busy_q;
  // lat_valid_q marks an accepted request that lost its slot to VGA.
  logic        lat_valid_q;
  logic        lat_we_q;
  logic [18:0] lat_adr_q;
  logic [7:0]  lat_dat_q;

  logic        cpu_accept;
  logic        req_we;
  logic [18:0] req_adr;
  logic [7:0]  req_dat;

  logic [18:0] sram_adr_q;
  logic [7:0]  sram_dat_q;
  logic        sram_dat_oe_q;
  logic        sram_ce_n_q;
  logic        sram_oe_n_q;
  logic        sram_we_n_q;
  logic        cpu_ack_q;
  logic [7:0]  cpu_dat_q;
  logic [7:0]  vga_hold_q;

  // Slot selection for the next cycle. A request accepted this edge is used
  // straight from the inputs; one deferred by VGA comes from the latch.
  always_comb begin
    cpu_accept = bus.I_cpu_stb && !cpu_ack_q && !cpu_busy_q;
    req_we     = lat_valid_q ? lat_we_q  : bus.I_cpu_we;
    req_adr    = lat_valid_q ? lat_adr_q : bus.I_cpu_adr;
    req_dat    = lat_valid_q ? lat_dat_q : bus.I_cpu_dat;
    slot_d     = SLOT_IDLE;
    if (bus.I_vga_req) begin
      slot_d = SLOT_VGA;
    end else if (lat_valid_q || cpu_accept) begin
      slot_d = req_we ? SLOT_CPU_WR : SLOT_CPU_RD;
    end
  end

  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      slot_q <= SLOT_IDLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  // SRAM pins are registered from the slot being entered; results of the
  // slot being left (ack, CPU read data, VGA hold) are captured at its end.
  always_ff @(posedge I_vga_clk) begin
    if (I_reset) begin
      cpu_busy_q    <= 1'b0;
      lat_valid_q   <= 1'b0;
      lat_we_q      <= 1'b0;
      lat_adr_q     <= '0;
      lat_dat_q     <= '0;
      sram_adr_q    <= '0;
      sram_dat_q    <= '0;
      sram_dat_oe_q <= 1'b0;
      sram_ce_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
      cpu_ack_q     <= 1'b0;
      cpu_dat_q     <= '0;
      vga_hold_q    <= '0;
    end else begin
      if (cpu_accept) begin
        lat_we_q  <= bus.I_cpu_we;
        lat_adr_q <= bus.I_cpu_adr;
        lat_dat_q <= bus.I_cpu_dat;
      end
      lat_valid_q <= (lat_valid_q || cpu_accept) && bus.I_vga_req;
      cpu_busy_q  <= cpu_accept || (cpu_busy_q && bus.I_cpu_stb);

      case (slot_d)
        SLOT_VGA:    sram_adr_q <= bus.I_vga_adr;
        SLOT_CPU_RD: sram_adr_q <= req_adr;
        SLOT_CPU_WR: begin
          sram_adr_q <= req_adr;
          sram_dat_q <= req_dat;
        end
        default:     sram_adr_q <= sram_adr_q;
      endcase
      sram_ce_n_q   <= (slot_d == SLOT_IDLE);
      sram_oe_n_q   <= !((slot_d == SLOT_VGA) || (slot_d == SLOT_CPU_RD));
      sram_we_n_q   <= (slot_d != SLOT_CPU_WR);
      sram_dat_oe_q <= (slot_d == SLOT_CPU_WR);

      cpu_ack_q <= (slot_q == SLOT_CPU_RD) || (slot_q == SLOT_CPU_WR);
      if (slot_q == SLOT_CPU_RD) begin
        cpu_dat_q <= bus.I_sram_dat;
      end
      if (slot_q == SLOT_VGA) begin
        vga_hold_q <= bus.I_sram_dat;
      end
    end
  end

  assign bus.O_sram_adr    = sram_adr_q;
  assign bus.O_sram_dat    = sram_dat_q;
  assign bus.O_sram_dat_oe = sram_dat_oe_q;
  assign bus.O_sram_ce_n   = sram_ce_n_q;
  assign bus.O_sram_oe_n   = sram_oe_n_q;
  // Reset raised during a write slot lifts WE before the slot's closing edge,
  // so the abandoned write is never committed by the SRAM.
  assign bus.O_sram_we_n   = sram_we_n_q | I_reset;
  assign bus.O_cpu_ack     = cpu_ack_q;
  assign bus.O_cpu_dat     = cpu_dat_q;
  // During a VGA slot the SRAM byte is forwarded directly; otherwise the
  // byte captured at the end of the last VGA slot is shown.
  assign bus.O_vga_dat     = (slot_q == SLOT_VGA) ? bus.I_sram_dat : vga_hold_q;

endmodule

// File: tb/tb_extram_arbiter.sv
// tb_extram_arbiter -- self-checking bench for extram_arbiter. Contains an
// asynchronous SRAM model (512K x 8, commits a write on the clock edge that
// ends a cycle with ce_n=0/we_n=0) and a reference memory model that records
// the CPU writes the spec says must have happened.
module tb_extram_arbiter;

  logic clk = 1'b0;
  logic rst;

  extram_arbiter_if bus();

  extram_arbiter dut (
    .I_vga_clk (clk),
    .I_reset   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:524287];
  logic [7:0] ref_mem [logic [18:0]];
  int checks   = 0;
  int failures = 0;

  // Power-up content of the SRAM model; 0x20000 maps to 0x5A.
  function automatic logic [7:0] init_pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ 8'h1A;
  endfunction

  function automatic logic [7:0] ref_read(input logic [18:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pat(a);
  endfunction

  assign bus.I_sram_dat = mem[bus.O_sram_adr];

  // SRAM model
  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = init_pat(19'(i));
    forever begin
      @(posedge clk);
      if (!bus.O_sram_ce_n && !bus.O_sram_we_n) mem[bus.O_sram_adr] = bus.O_sram_dat;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.I_vga_req = 1'b0; bus.I_vga_adr = '0;
    bus.I_cpu_stb = 1'b0; bus.I_cpu_we = 1'b0; bus.I_cpu_adr = '0; bus.I_cpu_dat = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.O_sram_ce_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_ce_n got=%0b exp=1", bus.O_sram_ce_n); end
    checks++; if (bus.O_sram_oe_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_oe_n got=%0b exp=1", bus.O_sram_oe_n); end
    checks++; if (bus.O_sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_we_n got=%0b exp=1", bus.O_sram_we_n); end
    checks++; if (bus.O_sram_dat_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_dat_oe got=%0b exp=0", bus.O_sram_dat_oe); end
    checks++; if (bus.O_sram_adr !== 19'h0) begin failures++; $display("[TB] FAIL reset_sram_adr got=%h exp=0", bus.O_sram_adr); end
    checks++; if (bus.O_sram_dat !== 8'h0) begin failures++; $display("[TB] FAIL reset_sram_dat got=%h exp=0", bus.O_sram_dat); end
    checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack got=%0b exp=0", bus.O_cpu_ack); end
    checks++; if (bus.O_cpu_dat !== 8'h0) begin failures++; $display("[TB] FAIL reset_cpu_dat got=%h exp=0", bus.O_cpu_dat); end
    checks++; if (bus.O_vga_dat !== 8'h0) begin failures++; $display("[TB] FAIL reset_vga_dat got=%h exp=0", bus.O_vga_dat); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vga_single();
    bus.I_vga_req = 1'b1; bus.I_vga_adr = 19'h20000;
    @(negedge clk);
    bus.I_vga_req = 1'b0;
    checks++; if (bus.O_sram_adr !== 19'h20000) begin failures++; $display("[TB] FAIL vga_adr got=%h exp=20000", bus.O_sram_adr); end
    checks++; if (bus.O_sram_oe_n !== 1'b0 || bus.O_sram_ce_n !== 1'b0 || bus.O_sram_we_n !== 1'b1) begin
      failures++; $display("[TB] FAIL vga_strobes got ce_n=%0b oe_n=%0b we_n=%0b exp 0/0/1", bus.O_sram_ce_n, bus.O_sram_oe_n, bus.O_sram_we_n); end
    checks++; if (bus.O_sram_dat_oe !== 1'b0) begin failures++; $display("[TB] FAIL vga_dat_oe got=%0b exp=0", bus.O_sram_dat_oe); end
    checks++; if (bus.O_vga_dat !== 8'h5A) begin failures++; $display("[TB] FAIL vga_dat_t2 got=%h exp=5a", bus.O_vga_dat); end
    @(negedge clk);
    checks++; if (bus.O_vga_dat !== 8'h5A) begin failures++; $display("[TB] FAIL vga_dat_hold got=%h exp=5a", bus.O_vga_dat); end
    checks++; if (bus.O_sram_ce_n !== 1'b1) begin failures++; $display("[TB] FAIL vga_idle_ce_n got=%0b exp=1", bus.O_sram_ce_n); end
    @(negedge clk);
    checks++; if (bus.O_vga_dat !== 8'h5A) begin failures++; $display("[TB] FAIL vga_dat_hold2 got=%h exp=5a", bus.O_vga_dat); end
  endtask

  task automatic test_cpu_write();
    bus.I_cpu_stb = 1'b1; bus.I_cpu_we = 1'b1; bus.I_cpu_adr = 19'h00123; bus.I_cpu_dat = 8'hA5;
    @(negedge clk);
    checks++; if (bus.O_sram_we_n !== 1'b0 || bus.O_sram_oe_n !== 1'b1 || bus.O_sram_dat_oe !== 1'b1) begin
      failures++; $display("[TB] FAIL wr_strobes got we_n=%0b oe_n=%0b dat_oe=%0b exp 0/1/1", bus.O_sram_we_n, bus.O_sram_oe_n, bus.O_sram_dat_oe); end
    checks++; if (bus.O_sram_adr !== 19'h00123 || bus.O_sram_dat !== 8'hA5) begin
      failures++; $display("[TB] FAIL wr_bus got adr=%h dat=%h exp 00123/a5", bus.O_sram_adr, bus.O_sram_dat); end
    checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_early_ack got=%0b exp=0", bus.O_cpu_ack); end
    @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack_e1 got=%0b exp=1", bus.O_cpu_ack); end
    bus.I_cpu_stb = 1'b0;
    ref_mem[19'h00123] = 8'hA5;
    checks++; if (mem[19'h00123] !== 8'hA5) begin failures++; $display("[TB] FAIL wr_mem got=%h exp=a5", mem[19'h00123]); end
    @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b0 || bus.O_sram_we_n !== 1'b1) begin
      failures++; $display("[TB] FAIL wr_after got ack=%0b we_n=%0b exp 0/1", bus.O_cpu_ack, bus.O_sram_we_n); end
  endtask

  task automatic test_cpu_read_vga();
    logic [18:0] va;
    va = 19'h40000 | 19'($urandom_range(0, 32'h3FFFF));
    bus.I_vga_req = 1'b1; bus.I_vga_adr = va;
    bus.I_cpu_stb = 1'b1; bus.I_cpu_we = 1'b0; bus.I_cpu_adr = 19'h00123;
    @(negedge clk);
    bus.I_vga_req = 1'b0;
    checks++; if (bus.O_sram_adr !== va || bus.O_sram_oe_n !== 1'b0) begin
      failures++; $display("[TB] FAIL rdv_vga_first got adr=%h oe_n=%0b exp %h/0", bus.O_sram_adr, bus.O_sram_oe_n, va); end
    checks++; if (bus.O_vga_dat !== ref_read(va)) begin failures++; $display("[TB] FAIL rdv_vga_dat got=%h exp=%h", bus.O_vga_dat, ref_read(va)); end
    checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL rdv_ack_e1 got=%0b exp=0", bus.O_cpu_ack); end
    @(negedge clk);
    checks++; if (bus.O_sram_adr !== 19'h00123 || bus.O_sram_oe_n !== 1'b0 || bus.O_sram_we_n !== 1'b1 || bus.O_sram_dat_oe !== 1'b0) begin
      failures++; $display("[TB] FAIL rdv_cpu_slot got adr=%h oe_n=%0b we_n=%0b dat_oe=%0b exp 00123/0/1/0",
                           bus.O_sram_adr, bus.O_sram_oe_n, bus.O_sram_we_n, bus.O_sram_dat_oe); end
    @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b1 || bus.O_cpu_dat !== 8'hA5) begin
      failures++; $display("[TB] FAIL rdv_ack_e2 got ack=%0b dat=%h exp 1/a5", bus.O_cpu_ack, bus.O_cpu_dat); end
    bus.I_cpu_stb = 1'b0;
    @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL rdv_ack_single got=%0b exp=0", bus.O_cpu_ack); end
  endtask

  task automatic test_ack_hold();
    int acks, slots, ack_c;
    logic [7:0] d;
    d = 8'($urandom);
    // write, stb held two cycles past the ack
    acks = 0; slots = 0; ack_c = -1;
    bus.I_cpu_stb = 1'b1; bus.I_cpu_we = 1'b1; bus.I_cpu_adr = 19'h00200; bus.I_cpu_dat = d;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.O_sram_we_n) slots++;
      if (bus.O_cpu_ack) begin acks++; if (ack_c < 0) ack_c = c; end
      if (ack_c >= 0 && c == ack_c + 2) bus.I_cpu_stb = 1'b0;
    end
    ref_mem[19'h00200] = d;
    checks++; if (acks != 1) begin failures++; $display("[TB] FAIL hold_wr_acks got=%0d exp=1", acks); end
    checks++; if (slots != 1) begin failures++; $display("[TB] FAIL hold_wr_slots got=%0d exp=1", slots); end
    checks++; if (mem[19'h00200] !== d) begin failures++; $display("[TB] FAIL hold_wr_mem got=%h exp=%h", mem[19'h00200], d); end
    // read back, again holding stb past the ack
    acks = 0; slots = 0; ack_c = -1;
    bus.I_cpu_stb = 1'b1; bus.I_cpu_we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.O_sram_oe_n) slots++;
      if (bus.O_cpu_ack) begin
        acks++;
        if (ack_c < 0) begin
          ack_c = c;
          checks++; if (bus.O_cpu_dat !== d) begin failures++; $display("[TB] FAIL hold_rd_dat got=%h exp=%h", bus.O_cpu_dat, d); end
        end
      end
      if (ack_c >= 0 && c == ack_c + 2) bus.I_cpu_stb = 1'b0;
    end
    checks++; if (acks != 1) begin failures++; $display("[TB] FAIL hold_rd_acks got=%0d exp=1", acks); end
    checks++; if (slots != 1) begin failures++; $display("[TB] FAIL hold_rd_slots got=%0d exp=1", slots); end
  endtask

  task automatic test_reset_midwrite();
    logic [7:0] old;
    old = ref_read(19'h00123);
    bus.I_cpu_stb = 1'b1; bus.I_cpu_we = 1'b1; bus.I_cpu_adr = 19'h00123; bus.I_cpu_dat = ~old;
    @(negedge clk);
    checks++; if (bus.O_sram_we_n !== 1'b0) begin failures++; $display("[TB] FAIL rstw_slot got we_n=%0b exp=0", bus.O_sram_we_n); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL rstw_ack got=%0b exp=0", bus.O_cpu_ack); end
    checks++; if (bus.O_sram_ce_n !== 1'b1 || bus.O_sram_oe_n !== 1'b1 || bus.O_sram_we_n !== 1'b1 || bus.O_sram_dat_oe !== 1'b0) begin
      failures++; $display("[TB] FAIL rstw_strobes got ce_n=%0b oe_n=%0b we_n=%0b dat_oe=%0b exp 1/1/1/0",
                           bus.O_sram_ce_n, bus.O_sram_oe_n, bus.O_sram_we_n, bus.O_sram_dat_oe); end
    checks++; if (mem[19'h00123] !== old) begin failures++; $display("[TB] FAIL rstw_mem got=%h exp=%h", mem[19'h00123], old); end
    rst = 1'b0; bus.I_cpu_stb = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.O_cpu_ack !== 1'b0 || mem[19'h00123] !== old) begin
      failures++; $display("[TB] FAIL rstw_after got ack=%0b mem=%h exp 0/%h", bus.O_cpu_ack, mem[19'h00123], old); end
  endtask

  task automatic test_random();
    int cyc, ops_done, ops_started, cooldown, edges, exp_lat;
    bit active, vreq, last_vreq;
    logic [18:0] vadr, last_vadr, c_adr;
    logic c_we;
    logic [7:0] c_dat;
    cyc = 0; ops_done = 0; ops_started = 0; cooldown = 0; edges = 0; exp_lat = 0;
    active = 0; last_vreq = 0; last_vadr = '0; c_adr = '0; c_we = 0; c_dat = '0;
    while ((cyc < 640 || ops_done < 50) && cyc < 3000) begin
      vreq = (cyc < 640) && (cyc % 2 == 0);
      vadr = 19'h40000 | 19'($urandom_range(0, 32'h3FFFF));
      bus.I_vga_req = vreq; bus.I_vga_adr = vadr;
      if (cooldown > 0) cooldown--;
      else if (!active && ops_started < 50 && $urandom_range(0, 1) == 1) begin
        c_adr = 19'h00100 + 19'($urandom_range(0, 15));
        c_we  = 1'($urandom_range(0, 1));
        c_dat = 8'($urandom);
        bus.I_cpu_stb = 1'b1; bus.I_cpu_we = c_we; bus.I_cpu_adr = c_adr; bus.I_cpu_dat = c_dat;
        active = 1; edges = 0; exp_lat = vreq ? 2 : 1; ops_started++;
      end
      @(negedge clk);
      cyc++;
      checks++; if (bus.O_sram_dat_oe === 1'b1 && bus.O_sram_oe_n === 1'b0) begin
        failures++; $display("[TB] FAIL rnd_bus_conflict cyc=%0d got dat_oe=1 oe_n=0 exp no overlap", cyc); end
      if (vreq) begin
        checks++; if (bus.O_vga_dat !== ref_read(vadr)) begin
          failures++; $display("[TB] FAIL rnd_vga_t2 adr=%h got=%h exp=%h", vadr, bus.O_vga_dat, ref_read(vadr)); end
      end
      if (last_vreq) begin
        checks++; if (bus.O_vga_dat !== ref_read(last_vadr)) begin
          failures++; $display("[TB] FAIL rnd_vga_hold adr=%h got=%h exp=%h", last_vadr, bus.O_vga_dat, ref_read(last_vadr)); end
      end
      if (active) begin
        edges++;
        if (bus.O_cpu_ack === 1'b1) begin
          checks++; if (edges - 1 != exp_lat) begin
            failures++; $display("[TB] FAIL rnd_cpu_latency got=%0d exp=%0d", edges - 1, exp_lat); end
          if (c_we) ref_mem[c_adr] = c_dat;
          else begin
            checks++; if (bus.O_cpu_dat !== ref_read(c_adr)) begin
              failures++; $display("[TB] FAIL rnd_cpu_rd adr=%h got=%h exp=%h", c_adr, bus.O_cpu_dat, ref_read(c_adr)); end
          end
          bus.I_cpu_stb = 1'b0; active = 0; ops_done++; cooldown = 1;
        end else if (edges > 4) begin
          checks++; failures++;
          $display("[TB] FAIL rnd_cpu_timeout adr=%h got no ack exp ack within 3 edges", c_adr);
          bus.I_cpu_stb = 1'b0; active = 0; ops_done++; cooldown = 1;
        end
      end else begin
        checks++; if (bus.O_cpu_ack !== 1'b0) begin failures++; $display("[TB] FAIL rnd_spurious_ack got=%0b exp=0", bus.O_cpu_ack); end
      end
      last_vreq = vreq; last_vadr = vadr;
    end
    bus.I_vga_req = 1'b0; bus.I_cpu_stb = 1'b0;
    checks++; if (ops_done != 50) begin failures++; $display("[TB] FAIL rnd_ops_done got=%0d exp=50", ops_done); end
    foreach (ref_mem[k]) begin
      checks++; if (mem[k] !== ref_mem[k]) begin failures++; $display("[TB] FAIL rnd_mem adr=%h got=%h exp=%h", k, mem[k], ref_mem[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_vga_single();
    test_cpu_write();
    test_cpu_read_vga();
    test_ack_hold();
    test_reset_midwrite();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
